// File: rtl/doodle_sprite_fetch.sv
// rtl/doodle_sprite_fetch.sv - per-pixel doodle sprite RAM fetch, alignment, keying and hurt blink
//
// Purpose: once per frame latches the doodle position/facing, turns each raster
// pixel into a sprite RAM read address (mirrored when facing right), aligns the
// RAM's one-cycle read data with a delayed hit flag, drops the key colour and
// gates the result with a hurt-blink visibility window. Fixed 3-cycle latency.
//
// Ports:
//   Clk            pixel clock, all state on rising edge
//   Reset          asynchronous active-high reset
//   frame_start    one-cycle pulse at start of vertical blank
//   doodle_x/y     sprite top-left, sampled on frame_start
//   facing_left    1 = native image, 0 = mirrored, sampled on frame_start
//   hurt           one-cycle pulse, starts/restarts the blink window
//   DrawX/DrawY/de current raster position and active-region flag
//   read_address5  sprite RAM read address
//   data_Out5      sprite RAM read data (one cycle after its address)
//   pixel_rgb      sprite colour, 0 when pixel_hit = 0
//   pixel_hit      opaque visible sprite pixel at the aligned raster position
module doodle_sprite_fetch #(
  parameter int          SPR_W        = 30,
  parameter int          SPR_H        = 29,
  parameter logic [23:0] KEY_RGB      = 24'hFF00FF,
  parameter int          BLINK_FRAMES = 60,
  parameter int          BLINK_HALF   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  doodle_x,
  input  logic [9:0]  doodle_y,
  input  logic        facing_left,
  input  logic        hurt,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        de,
  output logic [14:0] read_address5,
  input  logic [23:0] data_Out5,
  output logic [23:0] pixel_rgb,
  output logic        pixel_hit
);

  localparam int HB = $clog2(BLINK_HALF);
  localparam int PW = HB + 1;
  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [10:0] W11 = 11'(SPR_W);
  localparam logic [10:0] H11 = 11'(SPR_H);

  typedef enum logic {SOLID = 1'b0, BLINK = 1'b1} blink_state_t;

  logic [9:0]    sx, sy;
  logic          fl;
  logic [10:0]   x11, y11, sx11, sy11, dx, dy, col;
  logic          hit_a, v_a, v_b, visible, opaque;
  logic [14:0]   addr_a;
  blink_state_t  state, state_nx;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] phase;

  // Position is only sampled at frame start so the sprite never tears mid-frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sx <= '0;
      sy <= '0;
      fl <= 1'b1;
    end else if (frame_start) begin
      sx <= doodle_x;
      sy <= doodle_y;
      fl <= facing_left;
    end
  end

  // Stage A: box test and address. 11-bit sums keep sx+SPR_W from wrapping.
  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign sx11 = {1'b0, sx};
  assign sy11 = {1'b0, sy};

  always_comb begin
    dx     = x11 - sx11;
    dy     = y11 - sy11;
    hit_a  = de && (x11 >= sx11) && (x11 < sx11 + W11) &&
                   (y11 >= sy11) && (y11 < sy11 + H11);
    // Stored image faces left; mirror the column when facing right.
    col    = fl ? dx : (W11 - 11'd1 - dx);
    addr_a = 15'(dy) * 15'(SPR_W) + 15'(col);
  end

  // Stages A/B/C: address, RAM latency alignment, keyed and blink-gated output.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address5 <= '0;
      v_a           <= 1'b0;
      v_b           <= 1'b0;
      pixel_hit     <= 1'b0;
      pixel_rgb     <= '0;
    end else begin
      if (hit_a) read_address5 <= addr_a;
      v_a       <= hit_a;
      v_b       <= v_a;
      pixel_hit <= opaque;
      pixel_rgb <= opaque ? data_Out5 : 24'h0;
    end
  end

  assign opaque = v_b && visible && (data_Out5 != KEY_RGB);

  // Blink FSM: state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= SOLID;
    else       state <= state_nx;
  end

  // Blink FSM: next state. A hurt in the same cycle as frame_start wins.
  always_comb begin
    state_nx = state;
    case (state)
      SOLID: if (hurt) state_nx = BLINK;
      BLINK: if (!hurt && frame_start && bcnt == '0) state_nx = SOLID;
      default: state_nx = SOLID;
    endcase
  end

  // Blink FSM: output.
  always_comb begin
    visible = 1'b1;
    if (state == BLINK) visible = ~phase[HB];
  end

  // Window length and half-period counters, advanced once per frame.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bcnt  <= '0;
      phase <= '0;
    end else if (hurt) begin
      bcnt  <= BW'(BLINK_FRAMES - 1);
      phase <= '0;
    end else if (state == BLINK && frame_start) begin
      if (bcnt != '0) bcnt <= bcnt - BW'(1);
      phase <= phase + PW'(1);
    end
  end

endmodule

// File: tb/tb_doodle_sprite_fetch.sv
// tb/tb_doodle_sprite_fetch.sv - self-checking bench for doodle_sprite_fetch
module tb_doodle_sprite_fetch;

  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        Clk, Reset, frame_start, facing_left, hurt, de;
  logic [9:0]  doodle_x, doodle_y, DrawX, DrawY;
  logic [14:0] read_address5;
  logic [23:0] data_Out5, pixel_rgb;
  logic        pixel_hit;

  logic [23:0] ram [0:869];
  int total, bad;
  int m_sx, m_sy, m_addr, bk;
  bit m_fl, blinking;
  bit          exp_hit[$];
  logic [23:0] exp_rgb[$];
  logic        oh, eh;
  logic [23:0] orgb, ergb;
  logic [14:0] oa, ea;

  doodle_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .doodle_x(doodle_x), .doodle_y(doodle_y), .facing_left(facing_left),
    .hurt(hurt), .DrawX(DrawX), .DrawY(DrawY), .de(de),
    .read_address5(read_address5), .data_Out5(data_Out5),
    .pixel_rgb(pixel_rgb), .pixel_hit(pixel_hit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered-read sprite RAM.
  always @(posedge Clk) data_Out5 <= (read_address5 < 15'd870) ? ram[read_address5] : 24'h0;

  task automatic model_reset;
    m_sx = 0; m_sy = 0; m_fl = 1'b1; blinking = 1'b0; bk = 0; m_addr = 0;
    exp_hit.delete(); exp_rgb.delete();
    repeat (2) begin exp_hit.push_back(1'b0); exp_rgb.push_back(24'h0); end
  endtask

  task automatic set_px(input int x, input int y, input bit d);
    DrawX = 10'(x); DrawY = 10'(y); de = d;
  endtask

  // One clock: predict from the sprite rules, advance, sample the outputs.
  task automatic tick;
    bit in_box, vis, h;
    logic [23:0] w;
    int dx, dy;
    in_box = de && (int'(DrawX) >= m_sx) && (int'(DrawX) < m_sx + 30) &&
                   (int'(DrawY) >= m_sy) && (int'(DrawY) < m_sy + 29);
    vis = !blinking || (((bk / 4) % 2) == 0);
    h = 1'b0; w = 24'h0;
    if (in_box) begin
      dx = int'(DrawX) - m_sx;
      dy = int'(DrawY) - m_sy;
      m_addr = dy * 30 + (m_fl ? dx : 29 - dx);
      if (vis && ram[m_addr] !== KEY) begin h = 1'b1; w = ram[m_addr]; end
    end
    exp_hit.push_back(h); exp_rgb.push_back(w);
    @(posedge Clk);
    if (hurt) begin
      blinking = 1'b1; bk = 0;
    end else if (frame_start && blinking) begin
      bk++;
      if (bk == 60) blinking = 1'b0;
    end
    if (frame_start) begin m_sx = int'(doodle_x); m_sy = int'(doodle_y); m_fl = facing_left; end
    #1;
    oh = pixel_hit; orgb = pixel_rgb; oa = read_address5;
    eh = exp_hit.pop_front(); ergb = exp_rgb.pop_front(); ea = 15'(m_addr);
  endtask

  task automatic latch(input int x, input int y, input bit f);
    doodle_x = 10'(x); doodle_y = 10'(y); facing_left = f;
    frame_start = 1'b1; set_px(0, 0, 1'b0);
    tick;
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; frame_start = 1'b0; hurt = 1'b0; facing_left = 1'b1;
    doodle_x = '0; doodle_y = '0; set_px(0, 0, 1'b0);
    #12;
    total += 3;
    if (pixel_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b exp=0", pixel_hit); end
    if (pixel_rgb !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=0", pixel_rgb); end
    if (read_address5 !== 15'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", read_address5); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_native;
    latch(100, 200, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_px(100, 200, 1'b1); else set_px(0, 0, 1'b0);
      tick;
      total++;
      if (oh !== eh || orgb !== ergb || oa !== ea) begin bad++;
        $display("FAIL native i=%0d hit=%0b/%0b rgb=%h/%h addr=%0d/%0d", i, oh, eh, orgb, ergb, oa, ea); end
      if (i == 0) begin total++;
        if (oa !== 15'd0) begin bad++; $display("FAIL native_addr got=%0d exp=0", oa); end end
      if (i == 2) begin total++;
        if (oh !== 1'b1 || orgb !== 24'h123456) begin bad++;
          $display("FAIL native_pix got=%0b/%h exp=1/123456", oh, orgb); end end
    end
  endtask

  task automatic test_mirror;
    int xs[6] = '{100, 129, 130, 100, 0, 0};
    int ys[6] = '{200, 228, 200, 229, 0, 0};
    latch(100, 200, 1'b0);
    for (int i = 0; i < 6; i++) begin
      set_px(xs[i], ys[i], i < 4);
      tick;
      total++;
      if (oh !== eh || orgb !== ergb || oa !== ea) begin bad++;
        $display("FAIL mirror i=%0d hit=%0b/%0b rgb=%h/%h addr=%0d/%0d", i, oh, eh, orgb, ergb, oa, ea); end
      if (i == 0) begin total++; if (oa !== 15'd29) begin bad++; $display("FAIL mirror_addr0 got=%0d exp=29", oa); end end
      if (i == 1) begin total++; if (oa !== 15'd840) begin bad++; $display("FAIL mirror_addr1 got=%0d exp=840", oa); end end
      if (i >= 4) begin total++; if (oh !== 1'b0) begin bad++; $display("FAIL mirror_clip i=%0d got=%0b exp=0", i, oh); end end
    end
  endtask

  task automatic test_key_and_de;
    latch(100, 200, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_px(101, 200, 1'b1);
      else if (i == 1) set_px(100, 200, 1'b0);
      else set_px(0, 0, 1'b0);
      tick;
      total++;
      if (oh !== eh || orgb !== ergb || oa !== ea) begin bad++;
        $display("FAIL key i=%0d hit=%0b/%0b rgb=%h/%h addr=%0d/%0d", i, oh, eh, orgb, ergb, oa, ea); end
      if (i >= 2) begin total++;
        if (oh !== 1'b0 || orgb !== 24'h0) begin bad++; $display("FAIL key_drop i=%0d got=%0b/%h exp=0/0", i, oh, orgb); end end
    end
  endtask

  task automatic test_frame_latch;
    int xs[6] = '{100, 100, 100, 300, 0, 0};
    int eo[6] = '{-1, -1, 1, 1, 0, 1};
    latch(100, 200, 1'b1);
    doodle_x = 10'd300;
    for (int i = 0; i < 6; i++) begin
      frame_start = (i == 1);
      set_px(xs[i], 200, i < 4);
      tick;
      frame_start = 1'b0;
      total++;
      if (oh !== eh || orgb !== ergb || oa !== ea) begin bad++;
        $display("FAIL latch i=%0d hit=%0b/%0b rgb=%h/%h addr=%0d/%0d", i, oh, eh, orgb, ergb, oa, ea); end
      if (eo[i] >= 0) begin total++;
        if (oh !== 1'(eo[i])) begin bad++; $display("FAIL latch_hit i=%0d got=%0b exp=%0d", i, oh, eo[i]); end end
    end
  endtask

  task automatic test_random;
    int x, y, px, py;
    for (int r = 0; r < 4; r++) begin
      x = $urandom_range(0, 700); y = $urandom_range(0, 450);
      latch(x, y, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 152; i++) begin
        px = x + $urandom_range(0, 36) - 3; py = y + $urandom_range(0, 34) - 3;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        set_px(px, py, (i < 150) && ($urandom_range(0, 9) != 0));
        tick;
        total++;
        if (oh !== eh || orgb !== ergb || oa !== ea) begin bad++;
          $display("FAIL random r=%0d i=%0d hit=%0b/%0b rgb=%h/%h addr=%0d/%0d", r, i, oh, eh, orgb, ergb, oa, ea); end
      end
    end
  endtask

  task automatic test_blink;
    latch(100, 200, 1'b1);
    for (int f = 0; f < 97; f++) begin
      for (int t = 0; t < 4; t++) begin
        frame_start = (t == 0) && (f > 0);
        hurt = (t == 0) && (f == 0 || f == 30);
        if (t == 1) set_px(100, 200, 1'b1); else set_px(0, 0, 1'b0);
        tick;
        frame_start = 1'b0; hurt = 1'b0;
        total++;
        if (oh !== eh || orgb !== ergb) begin bad++;
          $display("FAIL blink f=%0d t=%0d hit=%0b/%0b rgb=%h/%h", f, t, oh, eh, orgb, ergb); end
        if (t == 3 && (f == 34 || f == 91)) begin total++;
          if (oh !== (f == 91)) begin bad++; $display("FAIL blink_vis f=%0d got=%0b exp=%0b", f, oh, f == 91); end end
      end
    end
  endtask

  task automatic test_reset_mid;
    set_px(100, 200, 1'b1);
    repeat (3) tick;
    #2 Reset = 1'b1;
    #1;
    total += 3;
    if (pixel_hit !== 1'b0) begin bad++; $display("FAIL midreset_hit got=%0b exp=0", pixel_hit); end
    if (pixel_rgb !== 24'h0) begin bad++; $display("FAIL midreset_rgb got=%h exp=0", pixel_rgb); end
    if (read_address5 !== 15'd0) begin bad++; $display("FAIL midreset_addr got=%0d exp=0", read_address5); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      set_px(0, 0, i < 4);
      tick;
      total++;
      if (oh !== eh || orgb !== ergb || oa !== ea) begin bad++;
        $display("FAIL resume i=%0d hit=%0b/%0b rgb=%h/%h addr=%0d/%0d", i, oh, eh, orgb, ergb, oa, ea); end
      if (i < 2) begin total++; if (oh !== 1'b0) begin bad++; $display("FAIL resume_quiet i=%0d got=%0b exp=0", i, oh); end end
      if (i == 2) begin total++;
        if (oh !== 1'b1 || orgb !== 24'h123456) begin bad++; $display("FAIL resume_first got=%0b/%h exp=1/123456", oh, orgb); end end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 870; i++)
      ram[i] = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
    ram[0] = 24'h123456;
    ram[1] = KEY;
    if (ram[29] === KEY) ram[29] = 24'h00A0B0;
    test_reset();
    test_native();
    test_mirror();
    test_key_and_de();
    test_frame_latch();
    test_random();
    test_blink();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/doodle_sprite_fetch.md
# doodle_sprite_fetch

Per-pixel sprite fetch stage that sits directly upstream and downstream of the 30×29 doodle sprite RAM (870 words × 24 bit, registered read). Once per frame it latches the doodle position and facing direction. For every raster pixel it computes the RAM read address, mirroring the stored left-facing image when the doodle faces right. It aligns the RAM's one-cycle read data with a delayed hit flag and drops the transparency key colour. It also drives a hurt-blink visibility counter. Output feeds the color mapper's layer mux.

## Interface
- SPR_W, 30, sprite width in pixels
- SPR_H, 29, sprite height in pixels (SPR_W*SPR_H = 870 = RAM depth)
- KEY_RGB, 24'hFF00FF, transparent colour in RAM contents
- BLINK_FRAMES, 60, frames of blinking after a hurt pulse
- BLINK_HALF, 4, frames per visible/invisible half-period

- Clk  in  1  system/pixel clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- frame_start  in  1  one-cycle pulse at start of vertical blank
- doodle_x  in  10  sprite top-left X, sampled on frame_start
- doodle_y  in  10  sprite top-left Y, sampled on frame_start
- facing_left  in  1  1 = native image, 0 = horizontally mirrored; sampled on frame_start
- hurt  in  1  one-cycle pulse; starts or restarts the blink window
- DrawX  in  10  current raster X
- DrawY  in  10  current raster Y
- de  in  1  DrawX/DrawY are in the active region
- read_address5  out  15  sprite RAM read address
- data_Out5  in  24  sprite RAM read data, valid one cycle after its address
- pixel_rgb  out  24  sprite colour; 0 when pixel_hit = 0
- pixel_hit  out  1  opaque sprite pixel present at the aligned raster position

## Operation
- Frame latch: on frame_start, register doodle_x, doodle_y and facing_left into sx, sy and fl. These inputs are ignored at all other times, so the sprite cannot tear mid-frame.
- Stage A (edge after DrawX/DrawY):
  - dx = {1'b0,DrawX} − {1'b0,sx}, 11 bit; dy likewise.
  - hitA = de & (DrawX ≥ sx) & (DrawX < sx+SPR_W) & (DrawY ≥ sy) & (DrawY < sy+SPR_H). Compare using 11-bit sums, so sx+SPR_W never wraps.
  - col = fl ? dx : SPR_W−1−dx.
  - Register read_address5 = dy*SPR_W + col when hitA, else hold the previous value. Upper bits are always 0, and the address is ≤ 869.
  - Register hitA into vA.
- Stage B (RAM): the RAM presents data_Out5 for read_address5 one edge later. vA is delayed one edge into vB.
- Stage C (output), at the edge after vB:
  - pixel_hit <= vB & visible & (data_Out5 ≠ KEY_RGB).
  - pixel_rgb <= that same condition ? data_Out5 : 0.
- Blink FSM, with states SOLID and BLINK:
  - SOLID: visible = 1. On hurt, go to BLINK with bcnt = BLINK_FRAMES−1 and phase = 0.
  - BLINK: visible = ~phase[log2(BLINK_HALF)]. phase increments on each frame_start. bcnt decrements on each frame_start.
  - When bcnt = 0 and frame_start arrives, go to SOLID.
  - hurt while in BLINK reloads bcnt and phase.
  - hurt and frame_start in the same cycle: the hurt reload wins.
- Clipping: sprites partially off the right or bottom edge are clipped naturally by de. There is no negative-coordinate support.

## Timing
- Latency: DrawX/DrawY at edge N produces pixel_hit/pixel_rgb registered at edge N+3, i.e. a fixed 3-cycle pipeline. The downstream mux delays its other layers by 3 cycles.
- Throughput: one pixel per cycle. No stalls and no handshake.
- The position latch takes effect on the cycle after frame_start. A pixel already in flight completes with the old values.
- Reset values: read_address5 = 0, pixel_rgb = 0, pixel_hit = 0, vA = vB = 0, sx = sy = 0, fl = 1, FSM = SOLID, bcnt = phase = 0.
- Reset asserted mid-pipeline: outputs drop to 0 asynchronously. The first valid output comes 3 cycles after release.

## Test plan
- Sprite at (100,200), facing_left = 1, RAM word 0 = 24'h123456. DrawX = 100, DrawY = 200, de = 1 → read_address5 = 0 after 1 edge; pixel_hit = 1 and pixel_rgb = 24'h123456 after 3 edges.
- Same position, facing_left = 0, pixel (100,200) → read_address5 = 29. Pixel (129,228) → read_address5 = 840. Pixel (130,200) or (100,229) → pixel_hit = 0.
- RAM word containing 24'hFF00FF inside the box → pixel_hit = 0 and pixel_rgb = 0. Pixel with de = 0 inside the box → pixel_hit = 0.
- Change doodle_x mid-frame with no frame_start → hits are unchanged. Pulse frame_start → the new position applies from the next cycle.
- hurt pulse, then 60 frame_starts → visibility alternates 4 frames off / 4 frames on, returns to SOLID after the 60th. A second hurt at frame 30 extends the window to frame 90.
- Assert Reset during streaming → all outputs are 0 immediately. After release, outputs stay 0 for 3 cycles, then resume.
